// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ready fetches to instruction
// memory and loads the IF/ID register, honouring stall and branch/jump redirects.
module fetch_stage #(
  parameter int ADDRESS_INSTRUCCION = 32
) (
  input  logic                           clk,
  input  logic                           reset_pc,
  input  logic [ADDRESS_INSTRUCCION-1:0] pc_in,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [ADDRESS_INSTRUCCION-1:0] branch_target,
  input  logic                           jump,
  input  logic [ADDRESS_INSTRUCCION-1:0] jump_target,
  output logic                           imem_req,
  output logic [ADDRESS_INSTRUCCION-1:0] imem_addr,
  input  logic [ADDRESS_INSTRUCCION-1:0] imem_rdata,
  input  logic                           imem_ready,
  output logic [ADDRESS_INSTRUCCION-1:0] ifid_pc,
  output logic [ADDRESS_INSTRUCCION-1:0] ifid_pc4,
  output logic [ADDRESS_INSTRUCCION-1:0] ifid_instr,
  output logic                           ifid_valid
);

  localparam int W = ADDRESS_INSTRUCCION;
  localparam logic [W-1:0] ALIGN_MASK = {{(W-2){1'b1}}, 2'b00};
  localparam logic [W-1:0] PC_STEP    = W'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_pc;
  logic [W-1:0]   r_drain_addr;
  logic [W-1:0]   r_hold_instr;
  logic [W-1:0]   r_hold_pc;
  logic [W-1:0]   r_ifid_pc;
  logic [W-1:0]   r_ifid_pc4;
  logic [W-1:0]   r_ifid_instr;
  logic           r_ifid_valid;

  logic           w_redirect;
  logic [W-1:0]   w_target;

  // Branch comes from EX and so belongs to an older instruction than a jump in ID.
  assign w_redirect = branch_taken | jump;
  assign w_target   = (branch_taken ? branch_target : jump_target) & ALIGN_MASK;

  // DRAIN keeps presenting the abandoned address until memory answers it.
  assign imem_req  = !reset_pc && (r_state != HOLD);
  assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

  assign ifid_pc    = r_ifid_pc;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_instr = r_ifid_instr;
  assign ifid_valid = r_ifid_valid;

  // NOTE: all state here uses non-blocking assignments so every branch reads the
  // pre-edge value of r_pc/r_state, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset_pc) begin
      r_state      <= FETCH;
      r_pc         <= pc_in & ALIGN_MASK;
      r_drain_addr <= '0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_ifid_pc    <= '0;
      r_ifid_pc4   <= '0;
      r_ifid_instr <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_redirect) begin
            r_pc         <= w_target;
            r_ifid_valid <= 1'b0;
            if (!imem_ready) begin
              r_drain_addr <= r_pc;
              r_state      <= DRAIN;
            end
          end else if (imem_ready) begin
            r_pc <= r_pc + PC_STEP;
            if (!stall) begin
              r_ifid_pc    <= r_pc;
              r_ifid_pc4   <= r_pc + PC_STEP;
              r_ifid_instr <= imem_rdata;
              r_ifid_valid <= 1'b1;
            end else begin
              r_hold_instr <= imem_rdata;
              r_hold_pc    <= r_pc;
              r_state      <= HOLD;
            end
          end else if (!stall) begin
            r_ifid_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (w_redirect) begin
            r_pc         <= w_target;
            r_ifid_valid <= 1'b0;
            r_state      <= FETCH;
          end else if (!stall) begin
            r_ifid_pc    <= r_hold_pc;
            r_ifid_pc4   <= r_hold_pc + PC_STEP;
            r_ifid_instr <= r_hold_instr;
            r_ifid_valid <= 1'b1;
            r_state      <= FETCH;
          end
        end

        DRAIN: begin
          r_ifid_valid <= 1'b0;
          if (w_redirect) r_pc <= w_target;
          if (imem_ready) r_state <= FETCH;
        end

        default: r_state <= FETCH;
      endcase
    end
  end

endmodule
